// File: rtl/attack_sched_pkg.sv
// Shared definitions for the attack scheduler.
//   phaseT          : per-player animation phase encoding (IDLE/WINDUP/ACTIVE/RECOVERY)
//   NONE..SUPER     : combo level encoding used on the request inputs
//   windupTicks etc : phase length tables indexed by combo level
//   DEF_DMG_Lx      : default damage per combo level
package attack_sched_pkg;

    typedef enum logic [1:0] {
        PhIdle     = 2'd0,
        PhWindup   = 2'd1,
        PhActive   = 2'd2,
        PhRecovery = 2'd3
    } phaseT;

    localparam logic [1:0] NONE    = 2'd0;
    localparam logic [1:0] NORMAL  = 2'd1;
    localparam logic [1:0] SPECIAL = 2'd2;
    localparam logic [1:0] SUPER   = 2'd3;

    localparam int unsigned DEF_DMG_L1 = 10;
    localparam int unsigned DEF_DMG_L2 = 25;
    localparam int unsigned DEF_DMG_L3 = 60;

    function automatic int unsigned windupTicks(input logic [1:0] lvl);
        int unsigned t;
        case (lvl)
            NORMAL:  t = 2;
            SPECIAL: t = 3;
            SUPER:   t = 5;
            default: t = 1;
        endcase
        return t;
    endfunction

    function automatic int unsigned activeTicks(input logic [1:0] lvl);
        int unsigned t;
        case (lvl)
            NORMAL:  t = 1;
            SPECIAL: t = 2;
            SUPER:   t = 2;
            default: t = 1;
        endcase
        return t;
    endfunction

    function automatic int unsigned recoveryTicks(input logic [1:0] lvl);
        int unsigned t;
        case (lvl)
            NORMAL:  t = 2;
            SPECIAL: t = 4;
            SUPER:   t = 8;
            default: t = 1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/attack_phase_fsm.sv
// Per-player attack sequencer: request latch, phase FSM with tick counter, stun counter
// and (with ATTACK_COOLDOWN_EN defined) a super-move cooldown that demotes level 3 to 2.
//   clk, rst_n   : clock, asynchronous active-low reset
//   gameTick     : advance strobe for all counters
//   comboMove    : requested combo level
//   hitIn        : this player is hit on the current tick; stunLoad is the stun to apply
//   abort        : drop an in-progress WINDUP back to IDLE
//   enterActive  : WINDUP->ACTIVE happens on this tick
//   level        : combo level of the running attack
//   phase        : current phase
//   stunned      : stun counter nonzero
module attack_phase_fsm
    import attack_sched_pkg::*;
#(
    parameter int unsigned TICK_W         = 8
`ifdef ATTACK_COOLDOWN_EN
    ,
    parameter int unsigned COOLDOWN_TICKS = 120
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gameTick,
    input  logic [1:0]        comboMove,
    input  logic              hitIn,
    input  logic [TICK_W-1:0] stunLoad,
    input  logic              abort,
    output logic              enterActive,
    output logic [1:0]        level,
    output phaseT             phase,
    output logic              stunned
);

    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] stunCnt;
    logic [1:0]        pending;
    logic [1:0]        reqLevel;

`ifdef ATTACK_COOLDOWN_EN
    logic [TICK_W-1:0] cooldown;

    assign reqLevel = (comboMove == SUPER && cooldown != '0) ? SPECIAL : comboMove;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown <= '0;
        end else if (gameTick) begin
            if (phase == PhRecovery && cnt == '0 && level == SUPER) begin
                cooldown <= TICK_W'(COOLDOWN_TICKS);
            end else if (cooldown != '0) begin
                cooldown <= cooldown - 1'b1;
            end
        end
    end
`else
    assign reqLevel = comboMove;
`endif

    assign stunned     = (stunCnt != '0);
    assign enterActive = gameTick && (phase == PhWindup) && (cnt == '0);

    // Counters hold (length - 1), so a phase lasts exactly its table length in ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PhIdle;
            cnt     <= '0;
            level   <= NONE;
            pending <= NONE;
            stunCnt <= '0;
        end else begin
            // Only ever upgrade the pending request; NONE is never greater.
            if (phase == PhIdle && !stunned && reqLevel > pending) begin
                pending <= reqLevel;
            end
            if (gameTick) begin
                if (hitIn) begin
                    stunCnt <= stunLoad;
                end else if (stunCnt != '0) begin
                    stunCnt <= stunCnt - 1'b1;
                end
                unique case (phase)
                    PhIdle: begin
                        if (hitIn) begin
                            pending <= NONE;
                        end else if (pending != NONE) begin
                            phase   <= PhWindup;
                            cnt     <= TICK_W'(windupTicks(pending) - 1);
                            level   <= pending;
                            pending <= NONE;
                        end
                    end
                    PhWindup: begin
                        if (abort) begin
                            phase <= PhIdle;
                            cnt   <= '0;
                            level <= NONE;
                        end else if (cnt == '0) begin
                            phase <= PhActive;
                            cnt   <= TICK_W'(activeTicks(level) - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PhActive: begin
                        if (cnt == '0) begin
                            phase <= PhRecovery;
                            cnt   <= TICK_W'(recoveryTicks(level) - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PhRecovery: begin
                        if (cnt == '0) begin
                            phase <= PhIdle;
                            level <= NONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/attack_scheduler.sv
// Attack scheduler: runs one attack_phase_fsm per fighter and resolves hits between them
// at WINDUP->ACTIVE. Optional super cooldown is enabled by defining ATTACK_COOLDOWN_EN.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   game_tick                  : advance strobe
//   combo_move_p0/p1           : combo requests (0 none .. 3 super)
//   blocking[n], in_range      : defender block state, fighters within hit distance
//   attacking[n], stunned[n]   : per-player status
//   phase_p0/p1                : per-player phase
//   hit_valid, hit_target[n]   : registered hit event, one clk after the tick
//   hit_damage_p0/p1           : damage dealt to each player, valid with hit_valid
module attack_scheduler
    import attack_sched_pkg::*;
#(
    parameter int unsigned TICK_W          = 8,
    parameter int unsigned STUN_TICKS      = 8,
    parameter int unsigned BLOCKSTUN_TICKS = 3,
    parameter int unsigned DMG_L1          = DEF_DMG_L1,
    parameter int unsigned DMG_L2          = DEF_DMG_L2,
    parameter int unsigned DMG_L3          = DEF_DMG_L3
`ifdef ATTACK_COOLDOWN_EN
    ,
    parameter int unsigned COOLDOWN_TICKS  = 120
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_tick,
    input  logic [1:0] combo_move_p0,
    input  logic [1:0] combo_move_p1,
    input  logic [1:0] blocking,
    input  logic       in_range,
    output logic [1:0] attacking,
    output logic [1:0] stunned,
    output logic [1:0] phase_p0,
    output logic [1:0] phase_p1,
    output logic       hit_valid,
    output logic [1:0] hit_target,
    output logic [7:0] hit_damage_p0,
    output logic [7:0] hit_damage_p1
);

    logic              enterActive0, enterActive1;
    logic [1:0]        level0, level1;
    phaseT             phase0, phase1;
    logic              stunned0, stunned1;
    logic [1:0]        hitOn;
    logic              trade;
    logic              abort0, abort1;
    logic [TICK_W-1:0] stunLoad0, stunLoad1;
    logic [7:0]        dmgTo0, dmgTo1;

    function automatic logic [7:0] dmgFor(input logic [1:0] lvl);
        logic [7:0] d;
        case (lvl)
            NORMAL:  d = 8'(DMG_L1);
            SPECIAL: d = 8'(DMG_L2);
            SUPER:   d = 8'(DMG_L3);
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    // An attacker lands unless the opponent enters ACTIVE on the same tick with a higher
    // level; equal levels therefore land both ways (a trade).
    always_comb begin
        hitOn[1]  = enterActive0 && in_range && !(enterActive1 && level1 > level0);
        hitOn[0]  = enterActive1 && in_range && !(enterActive0 && level0 > level1);
        trade     = hitOn[0] && hitOn[1];
        abort0    = hitOn[0] && (phase0 == PhWindup) && !trade;
        abort1    = hitOn[1] && (phase1 == PhWindup) && !trade;
        stunLoad0 = blocking[0] ? TICK_W'(BLOCKSTUN_TICKS) : TICK_W'(STUN_TICKS);
        stunLoad1 = blocking[1] ? TICK_W'(BLOCKSTUN_TICKS) : TICK_W'(STUN_TICKS);
        dmgTo0    = blocking[0] ? 8'd0 : dmgFor(level1);
        dmgTo1    = blocking[1] ? 8'd0 : dmgFor(level0);
    end

    attack_phase_fsm #(
        .TICK_W         (TICK_W)
`ifdef ATTACK_COOLDOWN_EN
        ,
        .COOLDOWN_TICKS (COOLDOWN_TICKS)
`endif
    ) uFsm0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .gameTick    (game_tick),
        .comboMove   (combo_move_p0),
        .hitIn       (hitOn[0]),
        .stunLoad    (stunLoad0),
        .abort       (abort0),
        .enterActive (enterActive0),
        .level       (level0),
        .phase       (phase0),
        .stunned     (stunned0)
    );

    attack_phase_fsm #(
        .TICK_W         (TICK_W)
`ifdef ATTACK_COOLDOWN_EN
        ,
        .COOLDOWN_TICKS (COOLDOWN_TICKS)
`endif
    ) uFsm1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .gameTick    (game_tick),
        .comboMove   (combo_move_p1),
        .hitIn       (hitOn[1]),
        .stunLoad    (stunLoad1),
        .abort       (abort1),
        .enterActive (enterActive1),
        .level       (level1),
        .phase       (phase1),
        .stunned     (stunned1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid     <= 1'b0;
            hit_target    <= 2'b00;
            hit_damage_p0 <= 8'd0;
            hit_damage_p1 <= 8'd0;
        end else begin
            hit_valid     <= |hitOn;
            hit_target    <= hitOn;
            hit_damage_p0 <= hitOn[0] ? dmgTo0 : 8'd0;
            hit_damage_p1 <= hitOn[1] ? dmgTo1 : 8'd0;
        end
    end

    assign attacking = {phase1 != PhIdle, phase0 != PhIdle};
    assign stunned   = {stunned1, stunned0};
    assign phase_p0  = phase0;
    assign phase_p1  = phase1;

endmodule

// File: tb/tb_attack_scheduler.sv
module tb_attack_scheduler;

`ifdef ATTACK_COOLDOWN_EN
    localparam bit CoolEn = 1'b1;
`else
    localparam bit CoolEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_tick = 1'b0;
    logic [1:0] combo_move_p0 = 2'd0;
    logic [1:0] combo_move_p1 = 2'd0;
    logic [1:0] blocking = 2'b00;
    logic       in_range = 1'b0;
    logic [1:0] attacking, stunned, phase_p0, phase_p1, hit_target;
    logic       hit_valid;
    logic [7:0] hit_damage_p0, hit_damage_p1;

    attack_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .game_tick     (game_tick),
        .combo_move_p0 (combo_move_p0),
        .combo_move_p1 (combo_move_p1),
        .blocking      (blocking),
        .in_range      (in_range),
        .attacking     (attacking),
        .stunned       (stunned),
        .phase_p0      (phase_p0),
        .phase_p1      (phase_p1),
        .hit_valid     (hit_valid),
        .hit_target    (hit_target),
        .hit_damage_p0 (hit_damage_p0),
        .hit_damage_p1 (hit_damage_p1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phases: 0 idle, 1 windup, 2 active, 3 recovery; mRem = ticks left in the phase.
    int WIND[4] = '{0, 2, 3, 5};
    int ACT[4]  = '{0, 1, 2, 2};
    int REC[4]  = '{0, 2, 4, 8};
    int DMG[4]  = '{0, 10, 25, 60};
    int mPh[2], mRem[2], mLvl[2], mPend[2], mStun[2], mCool[2];
    logic       eHitValid;
    logic [1:0] eTarget;
    logic [7:0] eDmg[2];

    task automatic modelStep();
        int  cm[2];
        int  nPend[2];
        bit  ent[2];
        bit  hit[2];
        bit  trade;
        bit  coolLoad;
        int  e;
        cm[0] = int'(combo_move_p0);
        cm[1] = int'(combo_move_p1);
        eHitValid = 1'b0;
        eTarget   = 2'b00;
        eDmg[0]   = 8'd0;
        eDmg[1]   = 8'd0;
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                mPh[p] = 0; mRem[p] = 0; mLvl[p] = 0; mPend[p] = 0; mStun[p] = 0; mCool[p] = 0;
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            nPend[p] = mPend[p];
            if (mPh[p] == 0 && mStun[p] == 0) begin
                e = cm[p];
                if (CoolEn && e == 3 && mCool[p] > 0) e = 2;
                if (e > nPend[p]) nPend[p] = e;
            end
        end
        if (game_tick) begin
            for (int p = 0; p < 2; p++) ent[p] = (mPh[p] == 1 && mRem[p] == 1);
            for (int p = 0; p < 2; p++)
                hit[1-p] = ent[p] && in_range && !(ent[1-p] && mLvl[1-p] > mLvl[p]);
            trade = hit[0] && hit[1];
            for (int q = 0; q < 2; q++) begin
                if (hit[q]) begin
                    eTarget[q] = 1'b1;
                    eDmg[q] = blocking[q] ? 8'd0 : 8'(DMG[mLvl[1-q]]);
                end
            end
            eHitValid = hit[0] | hit[1];
            for (int p = 0; p < 2; p++) begin
                if (hit[p]) mStun[p] = blocking[p] ? 3 : 8;
                else if (mStun[p] > 0) mStun[p]--;
                coolLoad = 1'b0;
                case (mPh[p])
                    0: begin
                        if (hit[p]) nPend[p] = 0;
                        else if (mPend[p] > 0) begin
                            mPh[p] = 1; mRem[p] = WIND[mPend[p]]; mLvl[p] = mPend[p]; nPend[p] = 0;
                        end
                    end
                    1: begin
                        if (hit[p] && !trade) begin mPh[p] = 0; mLvl[p] = 0; end
                        else if (mRem[p] == 1) begin mPh[p] = 2; mRem[p] = ACT[mLvl[p]]; end
                        else mRem[p]--;
                    end
                    2: begin
                        if (mRem[p] == 1) begin mPh[p] = 3; mRem[p] = REC[mLvl[p]]; end
                        else mRem[p]--;
                    end
                    default: begin
                        if (mRem[p] == 1) begin
                            if (mLvl[p] == 3) coolLoad = 1'b1;
                            mPh[p] = 0; mLvl[p] = 0;
                        end else mRem[p]--;
                    end
                endcase
                if (coolLoad) mCool[p] = 120;
                else if (mCool[p] > 0) mCool[p]--;
            end
        end
        for (int p = 0; p < 2; p++) mPend[p] = nPend[p];
    endtask

    function automatic logic [26:0] expVec();
        return {eHitValid, eTarget, eDmg[0], eDmg[1], 2'(mPh[1]), 2'(mPh[0]),
                mStun[1] > 0, mStun[0] > 0, mPh[1] != 0, mPh[0] != 0};
    endfunction

    function automatic logic [26:0] dutVec();
        return {hit_valid, hit_target, hit_damage_p0, hit_damage_p1, phase_p1, phase_p0,
                stunned, attacking};
    endfunction

    // One clk: model sees the same pre-edge inputs, outputs sampled 1ns after the edge.
    task automatic step(input logic t);
        game_tick = t;
        modelStep();
        @(posedge clk);
        #1;
        game_tick = 1'b0;
        combo_move_p0 = 2'd0;
        combo_move_p1 = 2'd0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        blocking = 2'b00;
        in_range = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);
    endtask

    typedef struct {
        logic [1:0] lv0, lv1, blk;
        logic       rng;
        int         expTicks;
        logic       expValid;
        logic [1:0] expTarget;
        logic [7:0] expD0, expD1;
        logic [1:0] expStun, expPh1, expPh0;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen, anyBad;
        int  bTicks[2];
        logic [1:0] bLvl[2];
        logic [1:0] bBlk[2];

        vecs[0] = '{2'd1, 2'd0, 2'b00, 1'b1, 3, 1'b1, 2'b10, 8'd0,  8'd10, 2'b10, 2'd0, 2'd2};
        vecs[1] = '{2'd2, 2'd2, 2'b00, 1'b1, 4, 1'b1, 2'b11, 8'd25, 8'd25, 2'b11, 2'd2, 2'd2};
        vecs[2] = '{2'd3, 2'd1, 2'b00, 1'b1, 3, 1'b1, 2'b01, 8'd10, 8'd0,  2'b01, 2'd2, 2'd0};
        vecs[3] = '{2'd2, 2'd0, 2'b10, 1'b1, 4, 1'b1, 2'b10, 8'd0,  8'd0,  2'b10, 2'd0, 2'd2};
        vecs[4] = '{2'd1, 2'd0, 2'b00, 1'b0, 0, 1'b0, 2'b00, 8'd0,  8'd0,  2'b00, 2'd0, 2'd0};
        vecs[5] = '{2'd0, 2'd3, 2'b00, 1'b1, 6, 1'b1, 2'b01, 8'd60, 8'd0,  2'b01, 2'd2, 2'd0};
        vecs[6] = '{2'd2, 2'd1, 2'b01, 1'b1, 3, 1'b1, 2'b01, 8'd0,  8'd0,  2'b01, 2'd2, 2'd0};
        vecs[7] = '{2'd3, 2'd3, 2'b11, 1'b1, 6, 1'b1, 2'b11, 8'd0,  8'd0,  2'b11, 2'd2, 2'd2};
        vecs[8] = '{2'd2, 2'd3, 2'b00, 1'b1, 4, 1'b1, 2'b10, 8'd0,  8'd25, 2'b10, 2'd0, 2'd2};

        // Reset state
        doReset();
        check("reset outputs", 64'(dutVec()), 64'd0);

        // Table: both requests latched on one clk, then a tick every clk until a hit
        for (int i = 0; i < 9; i++) begin
            doReset();
            blocking = vecs[i].blk;
            in_range = vecs[i].rng;
            combo_move_p0 = vecs[i].lv0;
            combo_move_p1 = vecs[i].lv1;
            step(1'b0);
            n = 0;
            seen = 1'b0;
            for (int k = 1; k <= 20 && !seen; k++) begin
                step(1'b1);
                if (hit_valid) begin seen = 1'b1; n = k; end
            end
            check($sformatf("vec%0d hit tick", i), 64'(n), 64'(vecs[i].expTicks));
            check($sformatf("vec%0d hit event", i),
                  64'({hit_valid, hit_target, hit_damage_p0, hit_damage_p1}),
                  64'({vecs[i].expValid, vecs[i].expTarget, vecs[i].expD0, vecs[i].expD1}));
            check($sformatf("vec%0d stun/phase", i), 64'({stunned, phase_p1, phase_p0}),
                  64'({vecs[i].expStun, vecs[i].expPh1, vecs[i].expPh0}));
        end

        // Simultaneous ACTIVE entry with different levels: higher wins, loser aborts
        doReset();
        in_range = 1'b1;
        combo_move_p0 = 2'd2;
        step(1'b0);
        step(1'b1);
        combo_move_p1 = 2'd1;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("priority win", 64'({hit_valid, hit_target, hit_damage_p0, hit_damage_p1,
              phase_p1, phase_p0}), 64'({1'b1, 2'b10, 8'd0, 8'd25, 2'd0, 2'd2}));

        // Reset held 3 clks mid-WINDUP
        doReset();
        in_range = 1'b1;
        combo_move_p0 = 2'd3;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("windup before reset", 64'({attacking, phase_p0}), 64'({2'b01, 2'd1}));
        rst_n = 1'b0;
        #1;
        check("async reset abort", 64'(dutVec()), 64'd0);
        for (int k = 0; k < 3; k++) step(1'b1);
        check("held in reset", 64'(dutVec()), 64'd0);
        rst_n = 1'b1;
        anyBad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            if (dutVec() != '0) anyBad = 1'b1;
        end
        check("quiet after reset", 64'(anyBad), 64'd0);

        // Stun durations (hit and block), and no request latched while stunned
        bLvl[0] = 2'd1; bBlk[0] = 2'b00; bTicks[0] = 8;
        bLvl[1] = 2'd2; bBlk[1] = 2'b10; bTicks[1] = 3;
        for (int c = 0; c < 2; c++) begin
            doReset();
            in_range = 1'b1;
            blocking = bBlk[c];
            combo_move_p0 = bLvl[c];
            step(1'b0);
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                step(1'b1);
                if (hit_valid) seen = 1'b1;
            end
            check($sformatf("stun%0d start", c), 64'(stunned), 64'(2'b10));
            combo_move_p1 = 2'd3;
            step(1'b0);
            n = 0;
            while (stunned[1] && n < 20) begin
                step(1'b1);
                n++;
            end
            check($sformatf("stun%0d length", c), 64'(n), 64'(bTicks[c]));
            for (int k = 0; k < 3; k++) step(1'b1);
            check($sformatf("stun%0d no latch", c), 64'(attacking[1]), 64'd0);
        end

        // Super cooldown
        doReset();
        combo_move_p0 = 2'd3;
        step(1'b0);
        for (int k = 0; k < 16; k++) step(1'b1);
        check("super done", 64'({attacking, phase_p0}), 64'd0);
        in_range = 1'b1;
        combo_move_p0 = 2'd3;
        step(1'b0);
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step(1'b1);
            if (hit_valid) begin seen = 1'b1; n = k; end
        end
        check("cooldown windup", 64'(n), CoolEn ? 64'd4 : 64'd6);
        check("cooldown damage", 64'(hit_damage_p1), CoolEn ? 64'd25 : 64'd60);
        for (int k = 0; k < 130; k++) step(1'b1);
        combo_move_p0 = 2'd3;
        step(1'b0);
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step(1'b1);
            if (hit_valid) begin seen = 1'b1; n = k; end
        end
        check("cooldown expired", 64'({n[7:0], hit_damage_p1}), 64'({8'd6, 8'd60}));

        // Randomized traffic against the reference model
        doReset();
        for (int i = 0; i < 4000; i++) begin
            combo_move_p0 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            combo_move_p1 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            if ($urandom_range(0, 9) == 0) blocking = 2'($urandom_range(0, 3));
            in_range = ($urandom_range(0, 7) != 0);
            step($urandom_range(0, 2) == 0);
            check($sformatf("random cycle %0d", i), 64'(dutVec()), 64'(expVec()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
